sv32_ptw: RTL
=============

# sv32_ptw

Two-level Sv32-style hardware page table walker that sits between the TLB miss path and the word-addressed page-table memory. It accepts a 20-bit virtual page number and issues one or two single-word reads to memory over a valid/ready request/response pair. It decodes each PTE and returns either a physical page number with permissions or a page fault. It handles one walk at a time and has no internal caching.

## Interface
Parameters:
- ROOT_BASE, 32'h0000_0400: byte address of the level-1 (root) page table.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- walk_req_valid_i  input  1  walk request valid.
- walk_req_ready_o  output  1  walker idle and able to accept a walk.
- walk_vpn_i  input  20  VPN; [19:10]=VPN1, [9:0]=VPN0.
- walk_resp_valid_o  output  1  walk result valid.
- walk_resp_ready_i  input  1  consumer accepts result.
- walk_ppn_o  output  20  translated PPN.
- walk_perm_o  output  3  {X,W,R} from the leaf PTE.
- walk_mega_o  output  1  result is a level-1 megapage.
- walk_fault_o  output  1  page fault; PPN and perm are 0 when set.
- mem_req_valid_o  output  1  memory read request valid.
- mem_req_ready_i  input  1  memory accepts request.
- mem_addr_o  output  32  word-aligned byte address of the PTE.
- mem_resp_valid_i  input  1  memory read data valid.
- mem_resp_ready_o  output  1  walker accepts read data.
- mem_data_i  input  32  PTE read data.

## Operation
- PTE format: [0]=V, [1]=R, [2]=W, [3]=X.
  - Leaf if any of R, W or X is set.
  - Non-leaf pointer: next table byte address = {pte[31:4],4'b0}.
  - Leaf PPN = pte[31:12].
- States: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - walk_req_ready_o=1.
  - On walk_req_valid_i, latch walk_vpn_i and go to L1_REQ.
- L1_REQ:
  - mem_addr_o = ROOT_BASE + {VPN1,2'b00}, 32-bit add, wraps modulo 2^32.
  - On mem_req_valid_o && mem_req_ready_i, go to L1_WAIT.
- L1_WAIT:
  - mem_resp_ready_o=1; on mem_resp_valid_i, decode the PTE.
  - V=0, or W=1 with R=0: fault, go to RESP.
  - Non-leaf: latch the next table base and go to L2_REQ.
  - Leaf: megapage handling, see Configuration.
- L2_REQ:
  - mem_addr_o = base + {VPN0,2'b00}.
  - Handshake as in L1_REQ, then go to L2_WAIT.
- L2_WAIT: decode the PTE, then go to RESP.
  - V=0, or W=1 with R=0: fault.
  - Non-leaf (R=W=X=0): fault.
  - Leaf: walk_ppn_o=pte[31:12], walk_perm_o=pte[3:1], walk_mega_o=0.
- RESP:
  - walk_resp_valid_o=1; all walk_* result outputs are held stable.
  - On walk_resp_ready_i, go to IDLE.
- mem_req_valid_o is registered and cleared in the cycle after the handshake.
  - It must never stay high past one accepted request, because memory treats valid as a new request whenever it is idle.
- Out-of-range memory reads return 0, which the walker reports as a V=0 fault.

## Timing
- Reset values: walk_req_ready_o=1; every other output 0; state IDLE.
- Reset mid-walk aborts the walk in one cycle. Memory shares rst, so no stale response survives.
- Walk accepted at cycle 0:
  - mem_req_valid_o rises at cycle 1.
  - Each memory access adds 3 cycles: request handshake at T, response valid at T+2, response consumed at T+2.
  - The next request is issued at T+3.
- walk_resp_valid_o rises the cycle after the final response is consumed.
  - Two-level walk with zero-stall memory: result at cycle 7.
  - Level-1 terminal result: cycle 4.
- walk_req_ready_o is 0 from the cycle after acceptance until the cycle after the RESP handshake.
  - No new walk can be accepted in the same cycle a result is handed off.
- mem_resp_valid_i arriving outside the WAIT states is ignored; mem_resp_ready_o=0 there.

## Configuration
- PTW_MEGAPAGE_EN defined: a valid level-1 leaf completes as a megapage.
  - walk_ppn_o = {pte[31:22], VPN0}.
  - walk_perm_o = pte[3:1], walk_mega_o=1.
  - No alignment check on pte[21:12].
- Not defined: any level-1 leaf returns walk_fault_o=1 and walk_mega_o=0 is hardwired.

## Test plan
Memory image (word index = byte address/4): 0x400=0x00000801, 0x404=0x12340007, 0x408=0, 0x800=0x1000000F, 0x804=0x1100000F, 0x808=0x12000007, 0x80C=0.
- VPN 0x00000 -> reads 0x400 then 0x800; PPN=0x10000, perm=3'b111, fault=0, valid at cycle 7.
- VPN 0x00002 -> reads 0x400 then 0x808; PPN=0x12000, perm=3'b011, fault=0.
- VPN 0x00003 -> reads 0x80C, which is 0; fault=1, PPN=0. VPN 0x00800 -> single read of 0x408; fault=1 at cycle 4.
- VPN 0x00401 with PTW_MEGAPAGE_EN -> single read of 0x404; PPN=0x12001, mega=1, perm=3'b011. Without the macro -> fault=1.
- Hold walk_resp_ready_i=0 for 5 cycles after a result -> outputs stable, walk_req_ready_o=0, mem_req_valid_o=0.
- Hold mem_req_ready_i=0 for 3 cycles -> mem_req_valid_o and mem_addr_o stable, exactly one request issued per level.
- Assert rst during L2_WAIT -> next cycle all outputs at reset values; a following walk of VPN 0x00001 returns PPN 0x11000.

Source files
------------

// File: rtl/sv32_ptw.sv
// sv32_ptw: two-level Sv32-style page table walker issuing one PTE read per level.
// Optional feature: define PTW_MEGAPAGE_EN to complete valid level-1 leaves as megapages.
module sv32_ptw #(
    parameter logic [31:0] ROOT_BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        walk_req_valid_i,
    output logic        walk_req_ready_o,
    input  logic [19:0] walk_vpn_i,
    output logic        walk_resp_valid_o,
    input  logic        walk_resp_ready_i,
    output logic [19:0] walk_ppn_o,
    output logic [2:0]  walk_perm_o,
    output logic        walk_mega_o,
    output logic        walk_fault_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_resp_valid_i,
    output logic        mem_resp_ready_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L2_REQ  = 3'd3,
        S_L2_WAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    // Invalid PTE, or the reserved write-without-read encoding.
    function automatic logic pte_invalid(input logic [31:0] pte);
        return (pte[0] == 1'b0) || (pte[2] && !pte[1]);
    endfunction

    function automatic logic pte_is_leaf(input logic [31:0] pte);
        return |pte[3:1];
    endfunction

    state_t      state_q, state_d;
    logic [19:0] vpn_q, vpn_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        resp_valid_q, resp_valid_d;
    logic [19:0] ppn_q, ppn_d;
    logic [2:0]  perm_q, perm_d;
    logic        mega_q, mega_d;
    logic        fault_q, fault_d;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            vpn_q           <= 20'd0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= 32'd0;
            resp_valid_q    <= 1'b0;
            ppn_q           <= 20'd0;
            perm_q          <= 3'd0;
            mega_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            vpn_q           <= vpn_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            resp_valid_q    <= resp_valid_d;
            ppn_q           <= ppn_d;
            perm_q          <= perm_d;
            mega_q          <= mega_d;
            fault_q         <= fault_d;
        end
    end

    // Next-state and next-output logic for the walk sequence.
    always_comb begin
        state_d         = state_q;
        vpn_d           = vpn_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        resp_valid_d    = resp_valid_q;
        ppn_d           = ppn_q;
        perm_d          = perm_q;
        mega_d          = mega_q;
        fault_d         = fault_q;

        case (state_q)
            S_IDLE: begin
                if (walk_req_valid_i) begin
                    vpn_d           = walk_vpn_i;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = ROOT_BASE + {20'd0, walk_vpn_i[19:10], 2'b00};
                    state_d         = S_L1_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // Valid drops right after the handshake so memory never sees a second request.
            S_L1_REQ, S_L2_REQ: begin
                if (mem_req_valid_q && mem_req_ready_i) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L2_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            S_L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    resp_valid_d = 1'b1;
                    ppn_d        = 20'd0;
                    perm_d       = 3'd0;
                    mega_d       = 1'b0;
                    fault_d      = 1'b1;
                    state_d      = S_RESP;
                    if (pte_invalid(mem_data_i)) begin
                        fault_d = 1'b1;
                    end else if (pte_is_leaf(mem_data_i)) begin
`ifdef PTW_MEGAPAGE_EN
                        ppn_d   = {mem_data_i[31:22], vpn_q[9:0]};
                        perm_d  = mem_data_i[3:1];
                        mega_d  = 1'b1;
                        fault_d = 1'b0;
`else
                        fault_d = 1'b1;
`endif
                    end else begin
                        resp_valid_d    = 1'b0;
                        fault_d         = 1'b0;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {mem_data_i[31:4], 4'b0000} + {20'd0, vpn_q[9:0], 2'b00};
                        state_d         = S_L2_REQ;
                    end
                end else begin
                    state_d = S_L1_WAIT;
                end
            end
            S_L2_WAIT: begin
                if (mem_resp_valid_i) begin
                    resp_valid_d = 1'b1;
                    mega_d       = 1'b0;
                    state_d      = S_RESP;
                    if (pte_invalid(mem_data_i) || !pte_is_leaf(mem_data_i)) begin
                        ppn_d   = 20'd0;
                        perm_d  = 3'd0;
                        fault_d = 1'b1;
                    end else begin
                        ppn_d   = mem_data_i[31:12];
                        perm_d  = mem_data_i[3:1];
                        fault_d = 1'b0;
                    end
                end else begin
                    state_d = S_L2_WAIT;
                end
            end
            S_RESP: begin
                if (walk_resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    ppn_d        = 20'd0;
                    perm_d       = 3'd0;
                    mega_d       = 1'b0;
                    fault_d      = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d         = S_IDLE;
                mem_req_valid_d = 1'b0;
                resp_valid_d    = 1'b0;
            end
        endcase
    end

    assign walk_req_ready_o  = (state_q == S_IDLE);
    assign mem_resp_ready_o  = (state_q == S_L1_WAIT) || (state_q == S_L2_WAIT);
    assign walk_resp_valid_o = resp_valid_q;
    assign walk_ppn_o        = ppn_q;
    assign walk_perm_o       = perm_q;
    assign walk_mega_o       = mega_q;
    assign walk_fault_o      = fault_q;
    assign mem_req_valid_o   = mem_req_valid_q;
    assign mem_addr_o        = mem_addr_q;

endmodule
